// File: rtl/mat_loader.sv
// Byte-serial frame decoder for the matrix-multiply front end: latches four
// dimension bytes, then stores two row-major matrices and flags completion.
module mat_loader #(
  parameter int DATA_W   = 8,
  parameter int MAX_DIM  = 4,
  parameter int MAX_ELEM = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [DATA_W-1:0]            data_send,
  input  logic [1:0]                   ctrl_logic,
  output logic [DATA_W-1:0]            R1,
  output logic [DATA_W-1:0]            C1,
  output logic [DATA_W-1:0]            R2,
  output logic [DATA_W-1:0]            C2,
  output logic [MAX_ELEM*DATA_W-1:0]   mat1_flat,
  output logic [MAX_ELEM*DATA_W-1:0]   mat2_flat,
  output logic                         load_done,
  output logic                         valid,
  output logic                         err
);

  localparam int PROD_W = $clog2(2*MAX_ELEM+1);
  localparam int DIM_W  = $clog2(MAX_DIM+1);
  localparam int ADDR_W = $clog2(MAX_ELEM);

  localparam logic [1:0] CTRL_DATA = 2'd0;
  localparam logic [1:0] CTRL_SIZE = 2'd1;
  localparam logic [1:0] CTRL_SYNC = 2'd2;

  typedef enum logic [1:0] {IDLE, SIZE, DATA, DONE} state_t;

  state_t              state;
  logic [2:0]          size_idx;
  logic [PROD_W-1:0]   elem_idx;
  logic [PROD_W-1:0]   n1;
  logic [PROD_W-1:0]   n_total;
  logic [ADDR_W-1:0]   a1;
  logic [ADDR_W-1:0]   a2;
  logic                dims_ok;

  // Products use only the low dimension bits; they are consulted only after
  // validation has confirmed every dimension is within 1..MAX_DIM.
  always_comb begin
    n1      = PROD_W'(R1[DIM_W-1:0]) * PROD_W'(C1[DIM_W-1:0]);
    n_total = n1 + PROD_W'(R2[DIM_W-1:0]) * PROD_W'(C2[DIM_W-1:0]);
    a1      = elem_idx[ADDR_W-1:0];
    a2      = ADDR_W'(elem_idx - n1);
    dims_ok = (R1 != '0) && (R1 <= DATA_W'(MAX_DIM)) &&
              (C1 != '0) && (C1 <= DATA_W'(MAX_DIM)) &&
              (R2 != '0) && (R2 <= DATA_W'(MAX_DIM)) &&
              (C2 != '0) && (C2 <= DATA_W'(MAX_DIM)) &&
              (C1 == R2);
  end

  always_ff @(posedge CLK) begin
    // NOTE: matrix storage is reset explicitly because it drives outputs that
    // must read 0 after reset; non-blocking assignments throughout.
    if (RST) begin
      state     <= IDLE;
      size_idx  <= '0;
      elem_idx  <= '0;
      R1        <= '0;
      C1        <= '0;
      R2        <= '0;
      C2        <= '0;
      mat1_flat <= '0;
      mat2_flat <= '0;
      load_done <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      load_done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          case (ctrl_logic)
            CTRL_SIZE: begin
              R1        <= data_send;
              size_idx  <= 3'd1;
              mat1_flat <= '0;
              mat2_flat <= '0;
              valid     <= 1'b0;
              err       <= 1'b0;
              state     <= SIZE;
            end
            CTRL_DATA: err <= 1'b1;
            default: ;
          endcase
        end
        SIZE: begin
          case (ctrl_logic)
            CTRL_SIZE: begin
              if (size_idx == 3'd4) begin
                err <= 1'b1;
              end else begin
                case (size_idx)
                  3'd0:    R1 <= data_send;
                  3'd1:    C1 <= data_send;
                  3'd2:    R2 <= data_send;
                  default: C2 <= data_send;
                endcase
                size_idx <= size_idx + 3'd1;
              end
            end
            CTRL_DATA: begin
              // A valid frame always has at least one matrix-1 element.
              if (size_idx == 3'd4 && dims_ok) begin
                mat1_flat[0 +: DATA_W] <= data_send;
                elem_idx               <= PROD_W'(1);
                state                  <= DATA;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
            CTRL_SYNC: begin
              err   <= 1'b1;
              state <= IDLE;
            end
            default: ;
          endcase
        end
        DATA: begin
          case (ctrl_logic)
            CTRL_DATA: begin
              if (elem_idx < n1) begin
                mat1_flat[a1*DATA_W +: DATA_W] <= data_send;
                elem_idx                       <= elem_idx + PROD_W'(1);
              end else if (elem_idx < n_total) begin
                mat2_flat[a2*DATA_W +: DATA_W] <= data_send;
                elem_idx                       <= elem_idx + PROD_W'(1);
              end else begin
                err <= 1'b1;
              end
            end
            CTRL_SYNC: begin
              if (elem_idx == n_total && !err) begin
                load_done <= 1'b1;
                valid     <= 1'b1;
                state     <= DONE;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
            CTRL_SIZE: begin
              err      <= 1'b1;
              R1       <= data_send;
              size_idx <= 3'd1;
              state    <= SIZE;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader: per-cycle flag vectors from a table plus
// hand-written checks of dimensions and matrix contents between segments.
module tb_mat_loader;

  localparam int DW = 8;
  localparam int ME = 16;
  localparam int MW = ME*DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] data_send;
  logic [1:0]    ctrl_logic;
  logic [DW-1:0] R1, C1, R2, C2;
  logic [MW-1:0] mat1_flat, mat2_flat;
  logic          load_done, valid, err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;

  // flags = {load_done, valid, err} expected after the edge that samples the inputs
  typedef struct {
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [2:0] flags;
  } vec_t;

  vec_t vecs[$];

  mat_loader #(.DATA_W(DW), .MAX_DIM(4), .MAX_ELEM(ME)) dut (
    .CLK(CLK), .RST(RST), .data_send(data_send), .ctrl_logic(ctrl_logic),
    .R1(R1), .C1(C1), .R2(R2), .C2(C2),
    .mat1_flat(mat1_flat), .mat2_flat(mat2_flat),
    .load_done(load_done), .valid(valid), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (load_done === 1'b1) done_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic [7:0] d);
    ctrl_logic = c;
    data_send  = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic [1:0] c, input logic [7:0] d, input logic [2:0] f);
    vecs.push_back('{c, d, f});
  endtask

  task automatic add_header(input logic [7:0] r1, input logic [7:0] c1,
                            input logic [7:0] r2, input logic [7:0] c2);
    add(2'd1, r1, 3'b000);
    add(2'd1, c1, 3'b000);
    add(2'd1, r2, 3'b000);
    add(2'd1, c2, 3'b000);
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      step(vecs[i].ctrl, vecs[i].data);
      check($sformatf("%s[%0d] flags", tag, i), MW'({load_done, valid, err}), MW'(vecs[i].flags));
    end
    vecs.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dims"}, MW'({R1, C1, R2, C2}), '0);
    check({tag, " mat1"}, mat1_flat, '0);
    check({tag, " mat2"}, mat2_flat, '0);
    check({tag, " flags"}, MW'({load_done, valid, err}), '0);
  endtask

  initial begin
    logic [MW-1:0] exp1, exp2;
    logic [7:0]    b [8];

    RST = 1'b1;
    step(2'd3, 8'h00);
    step(2'd3, 8'h00);
    check_all_zero("reset");
    RST = 1'b0;

    // Basic 2x2 frame with a reserved code mid-frame, trailing SYNC and a stray data byte in DONE
    add_header(8'd2, 8'd2, 8'd2, 8'd2);
    for (int k = 1; k <= 4; k++) add(2'd0, 8'(k), 3'b000);
    add(2'd3, 8'hFF, 3'b000);
    for (int k = 5; k <= 8; k++) add(2'd0, 8'(k), 3'b000);
    add(2'd2, 8'h00, 3'b110);
    add(2'd2, 8'h00, 3'b010);
    add(2'd0, 8'h77, 3'b011);
    run_vecs("basic");
    check("basic dims", MW'({R1, C1, R2, C2}), MW'(32'h02020202));
    check("basic mat1", mat1_flat, MW'(32'h04030201));
    check("basic mat2", mat2_flat, MW'(32'h08070605));

    // Non-square 2x3 * 3x2 frame
    add_header(8'd2, 8'd3, 8'd3, 8'd2);
    for (int k = 0; k < 12; k++) add(2'd0, 8'(8'h10 + k), 3'b000);
    add(2'd2, 8'h00, 3'b110);
    run_vecs("rect");
    check("rect dims", MW'({R1, C1, R2, C2}), MW'(32'h02030302));
    check("rect mat1", mat1_flat, MW'(48'h151413121110));
    check("rect mat2", mat2_flat, MW'(48'h1b1a19181716));

    // Inner dimensions disagree: first data byte fails validation and is dropped
    add_header(8'd2, 8'd2, 8'd3, 8'd2);
    add(2'd0, 8'h55, 3'b001);
    add(2'd2, 8'h00, 3'b001);
    add(2'd3, 8'h00, 3'b001);
    run_vecs("badhdr");
    check("badhdr mat1", mat1_flat, '0);

    // Short frame (7 bytes) and long frame (9 bytes)
    add_header(8'd2, 8'd2, 8'd2, 8'd2);
    for (int k = 0; k < 7; k++) add(2'd0, 8'(k + 1), 3'b000);
    add(2'd2, 8'h00, 3'b001);
    add(2'd2, 8'h00, 3'b001);
    add_header(8'd2, 8'd2, 8'd2, 8'd2);
    for (int k = 0; k < 8; k++) add(2'd0, 8'(k + 1), 3'b000);
    add(2'd0, 8'h99, 3'b001);
    add(2'd2, 8'h00, 3'b001);
    run_vecs("shortlong");

    // Fifth size byte, mid-frame header, early data in SIZE, SYNC in SIZE
    add_header(8'd2, 8'd2, 8'd2, 8'd2);
    add(2'd1, 8'd2, 3'b001);
    for (int k = 0; k < 8; k++) add(2'd0, 8'(k + 1), 3'b001);
    add(2'd2, 8'h00, 3'b001);
    add_header(8'd2, 8'd2, 8'd2, 8'd2);
    for (int k = 0; k < 3; k++) add(2'd0, 8'(k + 1), 3'b000);
    add(2'd1, 8'd4, 3'b001);
    run_vecs("abort");
    check("abort new R1", MW'(R1), MW'(8'd4));
    add(2'd0, 8'h00, 3'b001);
    add(2'd1, 8'd1, 3'b000);
    add(2'd2, 8'h00, 3'b001);
    run_vecs("sizeerr");

    // Four back-to-back random 2x2 frames
    done_count = 0;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 8; k++) b[k] = 8'($urandom);
      add_header(8'd2, 8'd2, 8'd2, 8'd2);
      for (int k = 0; k < 8; k++) add(2'd0, b[k], 3'b000);
      add(2'd2, 8'h00, 3'b110);
      add(2'd2, 8'h00, 3'b010);
      run_vecs($sformatf("rand%0d", f));
      exp1 = '0;
      exp2 = '0;
      for (int k = 0; k < 4; k++) begin
        exp1[k*8 +: 8] = b[k];
        exp2[k*8 +: 8] = b[k+4];
      end
      check($sformatf("rand%0d mat1", f), mat1_flat, exp1);
      check($sformatf("rand%0d mat2", f), mat2_flat, exp2);
    end
    check("rand done pulses", MW'(done_count), MW'(4));

    // Reset in the middle of DATA, then a clean frame
    add_header(8'd2, 8'd2, 8'd2, 8'd2);
    for (int k = 0; k < 3; k++) add(2'd0, 8'(8'hC0 + k), 3'b000);
    run_vecs("prerst");
    RST = 1'b1;
    step(2'd0, 8'hC3);
    check_all_zero("midrst");
    RST = 1'b0;
    add_header(8'd2, 8'd2, 8'd2, 8'd2);
    for (int k = 1; k <= 8; k++) add(2'd0, 8'(8'hA0 + k), 3'b000);
    add(2'd2, 8'h00, 3'b110);
    run_vecs("postrst");
    check("postrst mat1", mat1_flat, MW'(32'hA4A3A2A1));
    check("postrst mat2", mat2_flat, MW'(32'hA8A7A6A5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
